// File: rtl/rv_p4_pkg.sv
// Shared types and helpers for the egress cell path toward the SerDes TX ports.
package rv_p4_pkg;

    localparam int unsigned CELL_BYTES = 64;
    localparam int unsigned CELL_W     = CELL_BYTES * 8;

    typedef struct packed {
        logic              sof;
        logic              eof;
        logic [6:0]        eop_len;
        logic [CELL_W-1:0] data;
    } tx_cell_t;

    localparam int unsigned TX_CELL_W = $bits(tx_cell_t);

    typedef enum logic {
        FRM_IDLE,
        FRM_PKT
    } frm_state_e;

    // An EOF length of 0 or beyond the cell size means a completely filled cell.
    function automatic logic [6:0] fix_eop_len(input logic eof, input logic [6:0] len);
        if (eof && (len == 7'd0 || len > 7'(CELL_BYTES)))
            return 7'(CELL_BYTES);
        return len;
    endfunction

endpackage

// File: rtl/tx_cell_fifo.sv
// First-word fall-through cell FIFO for one TX port; the head entry reads as zero while empty.
module tx_cell_fifo
    import rv_p4_pkg::*;
#(
    parameter int unsigned DEPTH = 8
) (
    input  logic     clk,
    input  logic     rst_n,
    input  logic     push,
    input  tx_cell_t push_cell,
    input  logic     pop_ready,
    output logic     out_valid,
    output tx_cell_t out_cell,
    output logic     full
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam logic [AW:0] FULL_CNT = (AW + 1)'(DEPTH);
    localparam logic [AW:0] CNT_ONE  = (AW + 1)'(1);
    localparam logic [AW-1:0] PTR_ONE = AW'(1);

    logic [TX_CELL_W-1:0] mem [DEPTH];
    logic [AW-1:0]        wr_ptr;
    logic [AW-1:0]        rd_ptr;
    logic [AW:0]          count;
    logic [AW:0]          count_nxt;
    logic                 do_push;
    logic                 do_pop;

    assign out_valid = (count != '0);
    assign do_pop    = out_valid && pop_ready;
    assign do_push   = push && !full;
    assign out_cell  = out_valid ? tx_cell_t'(mem[rd_ptr]) : '0;

    always_comb begin
        count_nxt = count;
        case ({do_push, do_pop})
            2'b10:   count_nxt = count + CNT_ONE;
            2'b01:   count_nxt = count - CNT_ONE;
            default: count_nxt = count;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            full   <= 1'b0;
        end else begin
            if (do_push)
                wr_ptr <= wr_ptr + PTR_ONE;
            if (do_pop)
                rd_ptr <= rd_ptr + PTR_ONE;
            count <= count_nxt;
            // Registered from the next count so it tracks count==DEPTH exactly.
            full  <= (count_nxt == FULL_CNT);
        end
    end

    always_ff @(posedge clk) begin
        if (do_push)
            mem[wr_ptr] <= push_cell;
    end

endmodule

// File: rtl/mac_tx_dist.sv
// Demultiplexes the egress cell stream into per-port TX FIFOs with SOF/EOF framing enforcement.
module mac_tx_dist
    import rv_p4_pkg::*;
#(
    parameter int unsigned NUM_PORTS  = 32,
    parameter int unsigned FIFO_DEPTH = 8,
    parameter int unsigned PORT_W     = 5
) (
    input  logic                      clk_dp,
    input  logic                      rst_dp_n,
    input  logic                      in_valid,
    output logic                      in_ready,
    input  logic [PORT_W-1:0]         in_port,
    input  logic                      in_sof,
    input  logic                      in_eof,
    input  logic [6:0]                in_eop_len,
    input  logic [511:0]              in_data,
    output logic [NUM_PORTS-1:0]      tx_valid,
    output logic [NUM_PORTS-1:0]      tx_sof,
    output logic [NUM_PORTS-1:0]      tx_eof,
    output logic [NUM_PORTS*7-1:0]    tx_eop_len,
    output logic [NUM_PORTS*512-1:0]  tx_data,
    input  logic [NUM_PORTS-1:0]      tx_ready,
    output logic [15:0]               frm_err_cnt,
    output logic [NUM_PORTS-1:0]      port_full
);

    frm_state_e           state_q [NUM_PORTS];
    logic                 port_ok;
    logic                 cell_legal;
    logic                 accept;
    logic                 drop;
    logic [NUM_PORTS-1:0] push;
    tx_cell_t             in_cell;

    assign port_ok = (32'(in_port) < NUM_PORTS);
    assign accept  = in_valid && in_ready;

    always_comb begin
        in_ready   = 1'b1;
        cell_legal = 1'b0;
        if (port_ok) begin
            in_ready   = !port_full[in_port];
            // SOF is legal only when idle; continuation cells only inside a packet.
            cell_legal = ((state_q[in_port] == FRM_IDLE) == in_sof);
        end
    end

    assign drop = accept && !(port_ok && cell_legal);

    always_comb begin
        push = '0;
        for (int unsigned i = 0; i < NUM_PORTS; i++)
            push[i] = accept && port_ok && cell_legal && (in_port == PORT_W'(i));
    end

    always_comb begin
        in_cell.sof     = in_sof;
        in_cell.eof     = in_eof;
        in_cell.eop_len = fix_eop_len(in_eof, in_eop_len);
        in_cell.data    = in_data;
    end

    always_ff @(posedge clk_dp or negedge rst_dp_n) begin
        if (!rst_dp_n) begin
            for (int unsigned i = 0; i < NUM_PORTS; i++)
                state_q[i] <= FRM_IDLE;
            frm_err_cnt <= '0;
        end else begin
            for (int unsigned i = 0; i < NUM_PORTS; i++)
                if (push[i])
                    state_q[i] <= in_eof ? FRM_IDLE : FRM_PKT;
            if (drop && frm_err_cnt != '1)
                frm_err_cnt <= frm_err_cnt + 16'd1;
        end
    end

    for (genvar p = 0; p < NUM_PORTS; p++) begin : g_port
        tx_cell_t head;

        tx_cell_fifo #(
            .DEPTH (FIFO_DEPTH)
        ) u_fifo (
            .clk       (clk_dp),
            .rst_n     (rst_dp_n),
            .push      (push[p]),
            .push_cell (in_cell),
            .pop_ready (tx_ready[p]),
            .out_valid (tx_valid[p]),
            .out_cell  (head),
            .full      (port_full[p])
        );

        assign tx_sof[p]               = head.sof;
        assign tx_eof[p]               = head.eof;
        assign tx_eop_len[p*7 +: 7]    = head.eop_len;
        assign tx_data[p*512 +: 512]   = head.data;
    end

endmodule

// File: tb/tb_mac_tx_dist.sv
// Directed bench for mac_tx_dist: framing, FIFO ordering, backpressure, reset and interleaving.
module tb_mac_tx_dist;

    localparam int unsigned NP = 32;

    logic            clk_dp = 1'b0;
    logic            rst_dp_n = 1'b0;
    logic            in_valid = 1'b0;
    logic            in_ready;
    logic [4:0]      in_port = '0;
    logic            in_sof = 1'b0;
    logic            in_eof = 1'b0;
    logic [6:0]      in_eop_len = '0;
    logic [511:0]    in_data = '0;
    logic [NP-1:0]   tx_valid;
    logic [NP-1:0]   tx_sof;
    logic [NP-1:0]   tx_eof;
    logic [NP*7-1:0] tx_eop_len;
    logic [NP*512-1:0] tx_data;
    logic [NP-1:0]   tx_ready = '1;
    logic [15:0]     frm_err_cnt;
    logic [NP-1:0]   port_full;

    int checks = 0;
    int errors = 0;

    mac_tx_dist #(
        .NUM_PORTS  (32),
        .FIFO_DEPTH (8),
        .PORT_W     (5)
    ) dut (
        .clk_dp      (clk_dp),
        .rst_dp_n    (rst_dp_n),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .in_port     (in_port),
        .in_sof      (in_sof),
        .in_eof      (in_eof),
        .in_eop_len  (in_eop_len),
        .in_data     (in_data),
        .tx_valid    (tx_valid),
        .tx_sof      (tx_sof),
        .tx_eof      (tx_eof),
        .tx_eop_len  (tx_eop_len),
        .tx_data     (tx_data),
        .tx_ready    (tx_ready),
        .frm_err_cnt (frm_err_cnt),
        .port_full   (port_full)
    );

    always #5 clk_dp = ~clk_dp;

    function automatic logic [511:0] pat(input int p, input int k);
        logic [31:0] w;
        w = {p[15:0], k[15:0]};
        return {16{w}};
    endfunction

    task automatic chk(input string tag, input logic [511:0] obs, input logic [511:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Presents one cell, waits (bounded) for in_ready, and returns 1ns after the accepting edge.
    task automatic send(input int p, input logic s, input logic e,
                        input logic [6:0] len, input logic [511:0] d);
        int unsigned waitc;
        waitc      = 0;
        in_valid   = 1'b1;
        in_port    = 5'(p);
        in_sof     = s;
        in_eof     = e;
        in_eop_len = len;
        in_data    = d;
        #1;
        while (!in_ready && waitc < 50) begin
            @(posedge clk_dp); #1;
            waitc++;
        end
        if (waitc == 50) begin
            checks++;
            errors++;
            $error("FAIL send_timeout observed in_ready=0 expected 1 port %0d", p);
        end
        @(posedge clk_dp); #1;
        in_valid = 1'b0;
    endtask

    initial begin
        int sent [2];
        int rcvd [2];
        int q;

        #22 rst_dp_n = 1'b1;
        @(posedge clk_dp); #1;

        // Reset state
        chk("rst_tx_valid", tx_valid, '0);
        chk("rst_port_full", port_full, '0);
        chk("rst_err_cnt", frm_err_cnt, '0);
        chk("rst_tx_data5", tx_data[5*512 +: 512], '0);
        chk("rst_in_ready", in_ready, 1'b1);

        // Single-cell packet to port 5
        send(5, 1'b1, 1'b1, 7'd60, pat(5, 0));
        chk("p5_valid_vec", tx_valid, 32'h0000_0020);
        chk("p5_sof", tx_sof[5], 1'b1);
        chk("p5_eof", tx_eof[5], 1'b1);
        chk("p5_len", tx_eop_len[5*7 +: 7], 7'd60);
        chk("p5_data", tx_data[5*512 +: 512], pat(5, 0));
        chk("p5_err", frm_err_cnt, 16'd0);
        @(posedge clk_dp); #1;
        chk("p5_popped", tx_valid, '0);

        // 3-cell packet queued on stalled port 0, then drained in order
        tx_ready[0] = 1'b0;
        send(0, 1'b1, 1'b0, 7'd0, pat(0, 0));
        send(0, 1'b0, 1'b0, 7'd0, pat(0, 1));
        send(0, 1'b0, 1'b1, 7'd10, pat(0, 2));
        chk("p0_full", port_full[0], 1'b0);
        chk("p0_valid", tx_valid[0], 1'b1);
        tx_ready[0] = 1'b1;
        for (int k = 0; k < 3; k++) begin
            chk("p0_data", tx_data[0 +: 512], pat(0, k));
            chk("p0_sof", tx_sof[0], (k == 0));
            chk("p0_eof", tx_eof[0], (k == 2));
            if (k == 2) chk("p0_len", tx_eop_len[0 +: 7], 7'd10);
            @(posedge clk_dp); #1;
        end
        chk("p0_empty", tx_valid[0], 1'b0);

        // Backpressure on port 7; port 8 unaffected
        tx_ready[7] = 1'b0;
        for (int k = 0; k < 8; k++)
            send(7, (k == 0), 1'b0, 7'd0, pat(7, k));
        chk("p7_full", port_full[7], 1'b1);
        in_valid = 1'b1; in_port = 5'd7; in_sof = 1'b0; in_eof = 1'b1;
        in_eop_len = 7'd20; in_data = pat(7, 8);
        #1;
        chk("p7_in_ready", in_ready, 1'b0);
        @(posedge clk_dp); #1;
        chk("p7_hold_data", tx_data[7*512 +: 512], pat(7, 0));
        chk("p7_hold_sof", tx_sof[7], 1'b1);
        in_valid = 1'b0;
        send(8, 1'b1, 1'b1, 7'd33, pat(8, 0));
        chk("p8_valid", tx_valid[8], 1'b1);
        chk("p8_data", tx_data[8*512 +: 512], pat(8, 0));
        tx_ready[7] = 1'b1;
        for (int k = 0; k < 8; k++) begin
            chk("p7_drain", tx_data[7*512 +: 512], pat(7, k));
            @(posedge clk_dp); #1;
        end
        chk("p7_not_full", port_full[7], 1'b0);
        send(7, 1'b0, 1'b1, 7'd20, pat(7, 8));
        chk("p7_last_data", tx_data[7*512 +: 512], pat(7, 8));
        chk("p7_last_eof", tx_eof[7], 1'b1);
        chk("p7_last_len", tx_eop_len[7*7 +: 7], 7'd20);

        // Framing errors
        send(2, 1'b0, 1'b0, 7'd0, pat(2, 0));
        chk("fe_idle_cnt", frm_err_cnt, 16'd1);
        chk("fe_idle_drop", tx_valid[2], 1'b0);
        send(3, 1'b1, 1'b0, 7'd0, pat(3, 0));
        chk("fe_p3_first", tx_data[3*512 +: 512], pat(3, 0));
        send(3, 1'b1, 1'b0, 7'd0, pat(3, 9));
        chk("fe_pkt_cnt", frm_err_cnt, 16'd2);
        chk("fe_pkt_drop", tx_valid[3], 1'b0);
        send(3, 1'b0, 1'b0, 7'd0, pat(3, 1));
        chk("fe_p3_mid", tx_data[3*512 +: 512], pat(3, 1));
        chk("fe_p3_mid_sof", tx_sof[3], 1'b0);
        send(3, 1'b0, 1'b1, 7'd0, pat(3, 2));
        chk("fe_p3_eof", tx_eof[3], 1'b1);
        chk("fe_len0", tx_eop_len[3*7 +: 7], 7'd64);
        chk("fe_p3_last", tx_data[3*512 +: 512], pat(3, 2));
        send(4, 1'b1, 1'b1, 7'd100, pat(4, 0));
        chk("fe_len100", tx_eop_len[4*7 +: 7], 7'd64);
        chk("fe_cnt_final", frm_err_cnt, 16'd2);

        // Asynchronous reset mid-packet with port 1 full
        tx_ready[1] = 1'b0;
        for (int k = 0; k < 8; k++)
            send(1, (k == 0), 1'b0, 7'd0, pat(1, k));
        chk("rs_full_pre", port_full[1], 1'b1);
        chk("rs_valid_pre", tx_valid[1], 1'b1);
        #3 rst_dp_n = 1'b0;
        #1;
        chk("rs_tx_valid", tx_valid, '0);
        chk("rs_port_full", port_full, '0);
        chk("rs_err_cnt", frm_err_cnt, 16'd0);
        #2 rst_dp_n = 1'b1;
        @(posedge clk_dp); #1;
        tx_ready[1] = 1'b1;
        send(1, 1'b0, 1'b1, 7'd5, pat(1, 9));
        chk("rs_idle_drop_cnt", frm_err_cnt, 16'd1);
        chk("rs_idle_drop", tx_valid[1], 1'b0);
        send(1, 1'b1, 1'b1, 7'd12, pat(1, 10));
        chk("rs_new_valid", tx_valid[1], 1'b1);
        chk("rs_new_data", tx_data[1*512 +: 512], pat(1, 10));
        chk("rs_new_sof", tx_sof[1], 1'b1);

        // Interleaved packets to ports 30/31 with random sink readiness
        sent[0] = 0; sent[1] = 0; rcvd[0] = 0; rcvd[1] = 0; q = 0;
        for (int cyc = 0; cyc < 400 && (rcvd[0] < 8 || rcvd[1] < 8); cyc++) begin
            if (sent[q] >= 8) q = 1 - q;
            if (sent[q] < 8) begin
                in_valid   = 1'b1;
                in_port    = 5'(30 + q);
                in_sof     = (sent[q] % 4 == 0);
                in_eof     = (sent[q] % 4 == 3);
                in_eop_len = 7'(40 + q);
                in_data    = pat(30 + q, sent[q]);
            end else begin
                in_valid = 1'b0;
            end
            tx_ready[30] = 1'($urandom_range(0, 1));
            tx_ready[31] = 1'($urandom_range(0, 1));
            #1;
            for (int j = 0; j < 2; j++) begin
                if (tx_valid[30 + j] && tx_ready[30 + j]) begin
                    chk("il_data", tx_data[(30 + j)*512 +: 512], pat(30 + j, rcvd[j]));
                    chk("il_sof", tx_sof[30 + j], (rcvd[j] % 4 == 0));
                    chk("il_eof", tx_eof[30 + j], (rcvd[j] % 4 == 3));
                    if (rcvd[j] % 4 == 3)
                        chk("il_len", tx_eop_len[(30 + j)*7 +: 7], 7'(40 + j));
                    rcvd[j]++;
                end
            end
            if (in_valid && in_ready) begin
                sent[q]++;
                q = 1 - q;
            end
            @(posedge clk_dp); #1;
        end
        in_valid = 1'b0;
        chk("il_rcvd30", 32'(rcvd[0]), 32'd8);
        chk("il_rcvd31", 32'(rcvd[1]), 32'd8);
        chk("il_err_cnt", frm_err_cnt, 16'd1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
